fill_rect_sched: RTL and testbench

FILL_RECT_SCHED -- requirements
Module: fill_rect_sched

---
 rtl/fill_rect_sched.sv | 148 ++++++++++++++
 tb/tb_fill_rect_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fill_rect_sched.sv
// rtl/fill_rect_sched.sv - queues fill-rectangle commands and hands them one at a time to a fill engine
// FILL_SCHED_ZERO_SKIP_EN: when defined, zero-width/height commands are retired in IDLE without being issued.
module fill_rect_sched #(
  parameter int COLORW = 16,
  parameter int RANGEW = 9,
  parameter int DEPTH  = 4,
  parameter int DEPTHW = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [COLORW-1:0] cmd_color_i,
  input  logic [RANGEW-1:0] cmd_x0_i,
  input  logic [RANGEW-1:0] cmd_y0_i,
  input  logic [RANGEW-1:0] cmd_w_i,
  input  logic [RANGEW-1:0] cmd_h_i,
  output logic [COLORW-1:0] eng_color_o,
  output logic [RANGEW-1:0] eng_x0_o,
  output logic [RANGEW-1:0] eng_y0_o,
  output logic [RANGEW-1:0] eng_w_o,
  output logic [RANGEW-1:0] eng_h_o,
  output logic              eng_trig_o,
  input  logic              eng_busy_i,
  output logic [DEPTHW:0]   level_o,
  output logic              idle_o,
  output logic [7:0]        done_cnt_o,
  output logic              err_o,
  output logic              irq_o,
  input  logic              irq_clear_i
);

  typedef enum logic [1:0] {IDLE, LOAD, TRIG, RUN} state_t;

  localparam logic [DEPTHW:0] FULL_LEVEL = (DEPTHW + 1)'(DEPTH);

  state_t            state;
  logic [COLORW-1:0] q_color [DEPTH];
  logic [RANGEW-1:0] q_x0    [DEPTH];
  logic [RANGEW-1:0] q_y0    [DEPTH];
  logic [RANGEW-1:0] q_w     [DEPTH];
  logic [RANGEW-1:0] q_h     [DEPTH];
  logic [DEPTHW-1:0] wr_ptr;
  logic [DEPTHW-1:0] rd_ptr;
  logic [DEPTHW:0]   level;
  logic [3:0]        timer;
  logic              push;
  logic              pop;
  logic              skip;
  logic              irq_set;

  assign level_o     = level;
  assign cmd_ready_o = (level != FULL_LEVEL);
  assign idle_o      = (state == IDLE) && (level == '0);
  assign push        = cmd_valid_i && cmd_ready_o;
  assign pop         = (state == IDLE) && (level != '0);

`ifdef FILL_SCHED_ZERO_SKIP_EN
  assign skip = pop && ((q_w[rd_ptr] == '0) || (q_h[rd_ptr] == '0));
`else
  assign skip = 1'b0;
`endif

  // Queue-drained interrupt: only when the finishing command leaves nothing behind.
  assign irq_set = (state == RUN) && !eng_busy_i && (level == '0) && !push;

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_color[wr_ptr] <= cmd_color_i;
      q_x0[wr_ptr]    <= cmd_x0_i;
      q_y0[wr_ptr]    <= cmd_y0_i;
      q_w[wr_ptr]     <= cmd_w_i;
      q_h[wr_ptr]     <= cmd_h_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      timer       <= '0;
      eng_color_o <= '0;
      eng_x0_o    <= '0;
      eng_y0_o    <= '0;
      eng_w_o     <= '0;
      eng_h_o     <= '0;
      eng_trig_o  <= 1'b0;
      done_cnt_o  <= '0;
      err_o       <= 1'b0;
      irq_o       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase

      // Set wins over a same-cycle clear so a drain event is never lost.
      if (irq_set)          irq_o <= 1'b1;
      else if (irq_clear_i) irq_o <= 1'b0;

      case (state)
        IDLE: begin
          if (skip) begin
            done_cnt_o <= done_cnt_o + 1'b1;
          end else if (pop) begin
            eng_color_o <= q_color[rd_ptr];
            eng_x0_o    <= q_x0[rd_ptr];
            eng_y0_o    <= q_y0[rd_ptr];
            eng_w_o     <= q_w[rd_ptr];
            eng_h_o     <= q_h[rd_ptr];
            state       <= LOAD;
          end
        end
        LOAD: begin
          timer      <= '0;
          eng_trig_o <= 1'b1;
          state      <= TRIG;
        end
        TRIG: begin
          if (eng_busy_i) begin
            eng_trig_o <= 1'b0;
            state      <= RUN;
          end else if (timer == 4'd15) begin
            // Engine never picked the command up; drop it and flag.
            err_o      <= 1'b1;
            eng_trig_o <= 1'b0;
            state      <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RUN: begin
          if (!eng_busy_i) begin
            done_cnt_o <= done_cnt_o + 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fill_rect_sched.sv
// tb/tb_fill_rect_sched.sv - directed self-checking bench for fill_rect_sched
// Expectations for the zero-size case follow FILL_SCHED_ZERO_SKIP_EN as seen by the bench build.
module tb_fill_rect_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_color = '0;
  logic [8:0]  cmd_x0 = '0;
  logic [8:0]  cmd_y0 = '0;
  logic [8:0]  cmd_w = '0;
  logic [8:0]  cmd_h = '0;
  logic [15:0] eng_color;
  logic [8:0]  eng_x0;
  logic [8:0]  eng_y0;
  logic [8:0]  eng_w;
  logic [8:0]  eng_h;
  logic        eng_trig;
  logic        eng_busy = 1'b0;
  logic [2:0]  level;
  logic        idle;
  logic [7:0]  done_cnt;
  logic        err;
  logic        irq;
  logic        irq_clear = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fill_rect_sched dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_color_i(cmd_color), .cmd_x0_i(cmd_x0), .cmd_y0_i(cmd_y0),
    .cmd_w_i(cmd_w), .cmd_h_i(cmd_h),
    .eng_color_o(eng_color), .eng_x0_o(eng_x0), .eng_y0_o(eng_y0),
    .eng_w_o(eng_w), .eng_h_o(eng_h),
    .eng_trig_o(eng_trig), .eng_busy_i(eng_busy),
    .level_o(level), .idle_o(idle), .done_cnt_o(done_cnt),
    .err_o(err), .irq_o(irq), .irq_clear_i(irq_clear)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [15:0] c, input logic [8:0] x, input logic [8:0] y,
                         input logic [8:0] w, input logic [8:0] h);
    cmd_color = c; cmd_x0 = x; cmd_y0 = y; cmd_w = w; cmd_h = h;
  endtask

  task automatic push(input logic [15:0] c, input logic [8:0] x, input logic [8:0] y,
                      input logic [8:0] w, input logic [8:0] h);
    set_cmd(c, x, y, w, h);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_trig();
    int n = 0;
    while (!eng_trig && n < 20) begin
      tick();
      n++;
    end
    check("trig_seen", eng_trig, 1);
  endtask

  // Runs the engine side of one command that is already queued or in flight.
  task automatic serve(input logic [8:0] x);
    wait_trig();
    check("serve_x0", eng_x0, x);
    eng_busy = 1'b1;
    tick();
    check("serve_trig_drop", eng_trig, 0);
    tick();
    tick();
    eng_busy = 1'b0;
    tick();
  endtask

  task automatic clear_irq();
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    check("irq_cleared", irq, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    tick();
    tick();
    rst = 1'b0;
    check("rst_ready", cmd_ready, 1);
    check("rst_level", level, 0);
    check("rst_idle", idle, 1);
    check("rst_trig", eng_trig, 0);
    check("rst_done", done_cnt, 0);
    check("rst_err", err, 0);
    check("rst_irq", irq, 0);
    check("rst_x0", eng_x0, 0);

    // Single command latency and completion
    push(16'hF800, 9'd10, 9'd20, 9'd5, 9'd3);
    check("s1_level", level, 1);
    check("s1_trig_n", eng_trig, 0);
    tick();
    check("s1_color", eng_color, 16'hF800);
    check("s1_x0", eng_x0, 10);
    check("s1_y0", eng_y0, 20);
    check("s1_w", eng_w, 5);
    check("s1_h", eng_h, 3);
    check("s1_trig_n1", eng_trig, 0);
    tick();
    check("s1_trig_n2", eng_trig, 1);
    eng_busy = 1'b1;
    repeat (30) tick();
    check("s1_run_trig", eng_trig, 0);
    check("s1_run_done", done_cnt, 0);
    eng_busy = 1'b0;
    tick();
    check("s1_done", done_cnt, 1);
    check("s1_irq", irq, 1);
    check("s1_idle", idle, 1);
    check("s1_err", err, 0);
    clear_irq();

    // Fill the queue behind a running command
    push(16'h001F, 9'd200, 9'd0, 9'd7, 9'd7);
    wait_trig();
    eng_busy = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("s2_ready_pre", cmd_ready, 1);
      push(16'h0100 + 16'(i), 9'd100 + 9'(i), 9'd1, 9'd1, 9'd1);
    end
    check("s2_level_full", level, 4);
    check("s2_ready_full", cmd_ready, 0);
    check("s2_eng_hold", eng_x0, 200);
    set_cmd(16'h0104, 9'd104, 9'd1, 9'd1, 9'd1);
    cmd_valid = 1'b1;
    repeat (3) tick();
    check("s2_level_blocked", level, 4);
    eng_busy = 1'b0;
    tick();
    check("s2_done_first", done_cnt, 2);
    check("s2_level_nopop", level, 4);
    tick();
    check("s2_level_pop", level, 3);
    check("s2_ready_pop", cmd_ready, 1);
    tick();
    check("s2_level_fifth", level, 4);
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) serve(9'd100 + 9'(i));
    check("s2_done_all", done_cnt, 7);
    check("s2_irq", irq, 1);
    check("s2_idle", idle, 1);
    clear_irq();

    // Start timeout
    push(16'h07E0, 9'd50, 9'd5, 9'd2, 9'd2);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (eng_trig) cnt++;
    end
    check("s3_trig_cycles", cnt, 16);
    check("s3_err", err, 1);
    check("s3_done", done_cnt, 7);
    check("s3_irq", irq, 0);
    check("s3_idle", idle, 1);
    push(16'h0001, 9'd60, 9'd6, 9'd2, 9'd2);
    serve(9'd60);
    check("s3_next_done", done_cnt, 8);
    check("s3_err_sticky", err, 1);
    clear_irq();

    // irq clear coinciding with drain
    push(16'h0002, 9'd70, 9'd7, 9'd2, 9'd2);
    wait_trig();
    eng_busy = 1'b1;
    tick();
    eng_busy = 1'b0;
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    check("s4_irq_set_wins", irq, 1);
    check("s4_done", done_cnt, 9);
    clear_irq();

    // Reset while running with a backlog
    push(16'h0003, 9'd80, 9'd8, 9'd2, 9'd2);
    wait_trig();
    eng_busy = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) push(16'h0004, 9'd81 + 9'(i), 9'd8, 9'd2, 9'd2);
    check("s5_level_pre", level, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    eng_busy = 1'b0;
    check("s5_level", level, 0);
    check("s5_trig", eng_trig, 0);
    check("s5_irq", irq, 0);
    check("s5_done", done_cnt, 0);
    check("s5_err", err, 0);
    check("s5_ready", cmd_ready, 1);
    check("s5_x0", eng_x0, 0);
    repeat (3) tick();
    check("s5_done_after", done_cnt, 0);
    check("s5_idle_after", idle, 1);

    // Zero-width command
    push(16'hFFFF, 9'd90, 9'd9, 9'd0, 9'd4);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (eng_trig) cnt++;
    end
`ifdef FILL_SCHED_ZERO_SKIP_EN
    check("s6_trig_cycles", cnt, 0);
    check("s6_done", done_cnt, 1);
    check("s6_err", err, 0);
    check("s6_x0", eng_x0, 0);
`else
    check("s6_trig_cycles", cnt, 16);
    check("s6_done", done_cnt, 0);
    check("s6_err", err, 1);
    check("s6_x0", eng_x0, 90);
`endif
    check("s6_idle", idle, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
